// File: rtl/irda_rx_pkg.sv
// Shared types and constants for the IrDA SIR receive controller.
package irda_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAME_BITS     = 10;

endpackage

// File: rtl/irda_rx_sync.sv
// Two-flop synchronizer and rising-edge detector for the IrDA line.
// Optional IRDA_RX_GLITCH_FILTER_EN requires two consecutive synchronized highs.
module irda_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irda_rx,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

`ifdef IRDA_RX_GLITCH_FILTER_EN
    logic sync_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            sync_p3 <= 1'b0;
        end else begin
            sync_p0 <= irda_rx;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            sync_p3 <= sync_p2;
        end
    end

    // Edge counts only once the line has been high for two clocks.
    assign rise = sync_p1 & sync_p2 & ~sync_p3;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= irda_rx;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
`endif

endmodule

// File: rtl/irda_rx_ctrl.sv
// IrDA SIR receive controller: frames 10 bits (start, 8 data LSB-first, stop).
// Build option IRDA_RX_GLITCH_FILTER_EN enables the edge glitch filter in irda_rx_sync.
module irda_rx_ctrl
    import irda_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       irda_rx,
    input  logic       bit_done,
    output logic       bit_clear,
    output logic       bit_count,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam logic [3:0] CNT_MAX = 4'(OVERSAMPLE - 1);

    rx_state_t                 state;
    rx_state_t                 state_nxt;
    logic [3:0]                cnt;
    logic [3:0]                cnt_nxt;
    logic                      pulse_seen;
    logic                      pulse_nxt;
    logic [FRAME_BITS-1:0]     sreg;
    logic [FRAME_BITS-1:0]     sreg_nxt;
    logic [7:0]                data_nxt;
    logic                      valid_nxt;
    logic                      ferr_nxt;
    logic                      rise;
    logic                      bit_end;
    logic [3:0]                cnt_step;

    irda_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .irda_rx (irda_rx),
        .rise    (rise)
    );

    assign bit_clear = (state == IDLE);
    assign bit_end   = baud_tick && (cnt == CNT_MAX);
    assign cnt_step  = (cnt == CNT_MAX) ? 4'd0 : cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = pulse_seen;
        sreg_nxt  = sreg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        bit_count = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt   = 4'd0;
                pulse_nxt = 1'b0;
                if (rise) begin
                    state_nxt = RECV;
                    pulse_nxt = 1'b1;
                end
            end

            RECV: begin
                if (baud_tick) begin
                    cnt_nxt = cnt_step;
                end
                if (bit_end) begin
                    // A pulse anywhere in the bit period means a 0 bit.
                    sreg_nxt  = {~pulse_seen, sreg[FRAME_BITS-1:1]};
                    pulse_nxt = rise;
                    bit_count = 1'b1;
                    state_nxt = CHECK;
                end else if (rise) begin
                    pulse_nxt = 1'b1;
                end
            end

            CHECK: begin
                if (baud_tick) begin
                    cnt_nxt = cnt_step;
                end
                if (rise) begin
                    pulse_nxt = 1'b1;
                end
                if (bit_done) begin
                    data_nxt  = sreg[8:1];
                    state_nxt = IDLE;
                    if (!sreg[0] && sreg[FRAME_BITS-1]) begin
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = RECV;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            pulse_seen <= 1'b0;
            sreg       <= '0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pulse_seen <= pulse_nxt;
            sreg       <= sreg_nxt;
            rx_data    <= data_nxt;
            rx_valid   <= valid_nxt;
            frame_err  <= ferr_nxt;
        end
    end

endmodule

// File: tb/tb_irda_rx_ctrl.sv
// Self-checking bench for irda_rx_ctrl: directed IrDA frames with a frame-level scoreboard.
module tb_irda_rx_ctrl;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       irda_rx = 1'b0;
    logic       bit_done;
    logic       bit_clear;
    logic       bit_count;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int checks = 0;
    int passes = 0;
    int bc_total = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int div = 0;
    int bcnt = 0;

    bit         exp_kind_q[$];
    logic [7:0] exp_data_q[$];

    irda_rx_ctrl #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .irda_rx   (irda_rx),
        .bit_done  (bit_done),
        .bit_clear (bit_clear),
        .bit_count (bit_count),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    // Downstream 10-bit counter environment model.
    always @(posedge clk) begin
        if (bit_clear) bcnt <= 0;
        else if (bit_count) bcnt <= bcnt + 1;
    end
    assign bit_done = (bcnt == 10);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every strobe must match the next expected frame outcome.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_count) bc_total++;
            chk("strobe_exclusive", int'(rx_valid && frame_err), 0);
            chk("bit_count_in_idle", int'(bit_count && bit_clear), 0);
            if (rx_valid || frame_err) begin
                if (rx_valid) valid_cnt++;
                if (frame_err) err_cnt++;
                if (exp_kind_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    chk("strobe_kind", int'(rx_valid), int'(exp_kind_q.pop_front()));
                    chk("strobe_data", int'(rx_data), int'(exp_data_q.pop_front()));
                end
            end
        end
    end

    // Frame model: a pulse in a bit period reads as 0; good frame = start 0, stop 1.
    function automatic void expect_frame(input logic [9:0] mask);
        logic [9:0] bits;
        bits = ~mask;
        exp_kind_q.push_back(bits[0] == 1'b0 && bits[9] == 1'b1);
        exp_data_q.push_back(bits[8:1]);
    endfunction

    function automatic logic [9:0] byte_mask(input logic [7:0] b, input bit stop_pulse);
        return {stop_pulse, ~b, 1'b1};
    endfunction

    // Start pulse of start_w clocks at offset 0; other pulses mid-bit, 12 clocks wide.
    task automatic send_raw(input logic [9:0] mask, input int start_w, input int abort_bit);
        int len;
        int k;
        int ph;
        len = (start_w > 600) ? start_w + 100 : 10 * BIT_CLKS + 40;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            if (abort_bit >= 0 && c == abort_bit * BIT_CLKS + 40) begin
                rst_n = 1'b0;
                irda_rx = 1'b0;
                #2;
                chk("abort_bit_clear", int'(bit_clear), 1);
                chk("abort_bit_count", int'(bit_count), 0);
                chk("abort_rx_valid", int'(rx_valid), 0);
                chk("abort_frame_err", int'(frame_err), 0);
                chk("abort_rx_data", int'(rx_data), 8'h00);
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            k = c / BIT_CLKS;
            ph = c % BIT_CLKS;
            irda_rx = (c < start_w) ||
                      (k >= 1 && k <= 9 && mask[k] && ph >= 24 && ph < 36);
        end
        irda_rx = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_pulse, input string tag);
        int bc0;
        bc0 = bc_total;
        expect_frame(byte_mask(b, stop_pulse));
        send_raw(byte_mask(b, stop_pulse), 12, -1);
        chk({tag, "_done"}, exp_kind_q.size(), 0);
        chk({tag, "_bit_count"}, bc_total - bc0, 10);
        @(negedge clk);
        chk({tag, "_bit_clear"}, int'(bit_clear), 1);
    endtask

    initial begin
        int v0;
        int e0;
        int bc0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_clear", int'(bit_clear), 1);
        chk("rst_bit_count", int'(bit_count), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_rx_data", int'(rx_data), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        v0 = valid_cnt;
        send_byte(8'hA5, 1'b0, "a5");
        chk("a5_rx_data", int'(rx_data), 8'hA5);
        chk("a5_valid_pulses", valid_cnt - v0, 1);

        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'h3C, 1'b1, "3c");
        chk("3c_rx_data", int'(rx_data), 8'h3C);
        chk("3c_err_pulses", err_cnt - e0, 1);
        chk("3c_no_valid", valid_cnt - v0, 0);

        v0 = valid_cnt;
        send_byte(8'h00, 1'b0, "b2b_00");
        chk("b2b_00_rx_data", int'(rx_data), 8'h00);
        send_byte(8'hFF, 1'b0, "b2b_ff");
        chk("b2b_ff_rx_data", int'(rx_data), 8'hFF);
        chk("b2b_valid_pulses", valid_cnt - v0, 2);

        v0 = valid_cnt;
        e0 = err_cnt;
        send_raw(byte_mask(8'h5A, 1'b0), 12, 5);
        repeat (30) @(posedge clk);
        chk("abort_no_strobe", (valid_cnt - v0) + (err_cnt - e0), 0);
        send_byte(8'h5A, 1'b0, "5a");
        chk("5a_rx_data", int'(rx_data), 8'h5A);
        chk("5a_valid_pulses", valid_cnt - v0, 1);

        // Line held high well past a frame: one frame only, all data bits read 1.
        v0 = valid_cnt;
        bc0 = bc_total;
        expect_frame(10'b00_0000_0001);
        send_raw(10'b00_0000_0001, 900, -1);
        chk("hold_done", exp_kind_q.size(), 0);
        chk("hold_bit_count", bc_total - bc0, 10);
        chk("hold_valid_pulses", valid_cnt - v0, 1);
        chk("hold_rx_data", int'(rx_data), 8'hFF);
        repeat (20) @(posedge clk);

        e0 = err_cnt;
        bc0 = bc_total;
`ifdef IRDA_RX_GLITCH_FILTER_EN
        send_raw(10'b00_0000_0001, 1, -1);
        chk("glitch_bit_count", bc_total - bc0, 0);
        chk("glitch_no_err", err_cnt - e0, 0);
        @(negedge clk);
        chk("glitch_idle", int'(bit_clear), 1);
`else
        expect_frame(10'b10_0000_0001);
        send_raw(10'b10_0000_0001, 1, -1);
        chk("glitch_done", exp_kind_q.size(), 0);
        chk("glitch_bit_count", bc_total - bc0, 10);
        chk("glitch_err_pulses", err_cnt - e0, 1);
        chk("glitch_rx_data", int'(rx_data), 8'hFF);
`endif

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
